// File: rtl/inv_pkg.sv
// ============================================================================
// Module      : inv_pkg
// Description : Shared types and helper constants for the binary modular
//               inverter (binary_inv_ctrl) and its datapath helpers.
//               Supplies fallback values for the WORD_SIZE and CHAR macros
//               when the build does not define them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef CHAR
`define CHAR 13
`endif

package inv_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } inv_state_e;

    // Default step limit: the binary EEA needs fewer than 4*WORD_SIZE steps.
    function automatic int max_iter_default(input int ws);
        return 4 * ws;
    endfunction

    // Width of the (x + p) half-sum: one extra bit keeps the carry.
    function automatic int half_width(input int ws);
        return ws + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/binary_inv_ctrl_if.sv
// ============================================================================
// Module      : binary_inv_ctrl_if
// Description : Operand/result handshake bundle for binary_inv_ctrl.
//               master : operand producer + result consumer
//               slave  : the inverter
//   in_valid/in_ready/in_a              operand handshake
//   out_valid/out_ready/out_data/out_err result handshake
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

interface binary_inv_ctrl_if #(
    parameter int WORD_SIZE = `WORD_SIZE
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_a;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_err;

    modport master (
        output in_valid, in_a, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_a, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

`default_nettype wire

// File: rtl/mod_half_p.sv
// ============================================================================
// Module      : mod_half_p
// Description : Combinational x/2 mod p for odd p and x < p.
//               Even x shifts right; odd x computes (x + p) >> 1 using a
//               WORD_SIZE+1 bit sum so the carry becomes the MSB.
//               i_bypass passes i_x straight through (idle lane).
//   i_x      [WORD_SIZE-1:0] operand, < p
//   i_bypass               1 = pass-through
//   o_y      [WORD_SIZE-1:0] result, < p
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_half_p
    import inv_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int P         = 13
) (
    input  logic [WORD_SIZE-1:0] i_x,
    input  logic                 i_bypass,
    output logic [WORD_SIZE-1:0] o_y
);
    localparam int                  c_hw = half_width(WORD_SIZE);
    localparam logic [c_hw-1:0]     c_p  = c_hw'(P);

    logic [c_hw-1:0] w_sum;

    assign w_sum = {1'b0, i_x} + c_p;

    always_comb begin
        o_y = i_x;
        if (!i_bypass) begin
            if (i_x[0]) begin
                o_y = w_sum[c_hw-1:1];
            end else begin
                o_y = i_x >> 1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/mod_sub_p.sv
// ============================================================================
// Module      : mod_sub_p
// Description : Combinational (x - y) mod p for x, y < p.
//               Borrow of the extended difference selects between x - y and
//               x - y + p; both are taken modulo 2^WORD_SIZE, which is exact
//               because the true result is below p < 2^WORD_SIZE.
//   i_x, i_y [WORD_SIZE-1:0] operands, < p
//   o_d      [WORD_SIZE-1:0] result, < p
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_sub_p #(
    parameter int WORD_SIZE = 8,
    parameter int P         = 13
) (
    input  logic [WORD_SIZE-1:0] i_x,
    input  logic [WORD_SIZE-1:0] i_y,
    output logic [WORD_SIZE-1:0] o_d
);
    localparam logic [WORD_SIZE-1:0] c_p = WORD_SIZE'(P);

    logic [WORD_SIZE:0] w_diff;

    assign w_diff = {1'b0, i_x} - {1'b0, i_y};
    assign o_d    = w_diff[WORD_SIZE] ? (w_diff[WORD_SIZE-1:0] + c_p)
                                      : w_diff[WORD_SIZE-1:0];
endmodule

`default_nettype wire

// File: rtl/binary_inv_ctrl.sv
// ============================================================================
// Module      : binary_inv_ctrl
// Description : Sequential modular inverter, a^-1 mod p by the binary
//               extended Euclidean algorithm, one step per clock.
//   clk   : clock
//   rst   : synchronous active-high reset
//   bus   : binary_inv_ctrl_if.slave (operand in, result out, err flag)
// Build option: define INV_TIMEOUT_EN to add a step counter that aborts with
//               out_err after MAX_ITER steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef CHAR
`define CHAR 13
`endif

module binary_inv_ctrl
    import inv_pkg::*;
#(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int P         = `CHAR,
    parameter int MAX_ITER  = max_iter_default(WORD_SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    binary_inv_ctrl_if.slave bus
);
    localparam logic [WORD_SIZE-1:0] c_one = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] c_p   = WORD_SIZE'(P);

    inv_state_e           state_q, state_d;
    logic [WORD_SIZE-1:0] u_q, u_d, v_q, v_d;
    logic [WORD_SIZE-1:0] x1_q, x1_d, x2_q, x2_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_err_q, out_err_d;

    logic                 w_term_now, w_timeout, w_step;
    logic                 w_u_even, w_v_even, w_u_ge_v, w_half_u, w_half_v;
    logic [WORD_SIZE-1:0] w_x1_half, w_x2_half, w_x1_sub, w_x2_sub;
    logic [WORD_SIZE-1:0] w_u_nxt, w_v_nxt, w_x1_nxt, w_x2_nxt;

`ifdef INV_TIMEOUT_EN
    localparam int c_step_w = $clog2(MAX_ITER + 1);
    logic [c_step_w-1:0] step_q, step_d;
    assign w_timeout = (step_q == c_step_w'(MAX_ITER));
`else
    // MAX_ITER only shapes the timeout counter, absent in this build.
    logic w_unused_max_iter;
    assign w_unused_max_iter = MAX_ITER[0];
    assign w_timeout         = 1'b0;
`endif

    assign w_term_now = (u_q == c_one) || (v_q == c_one);
    assign w_step     = (state_q == ST_RUN) && !w_term_now && !w_timeout;
    assign w_u_even   = ~u_q[0];
    assign w_v_even   = ~v_q[0];
    assign w_u_ge_v   = (u_q >= v_q);
    assign w_half_u   = w_step && w_u_even;
    assign w_half_v   = w_step && !w_u_even && w_v_even;

    mod_half_p #(.WORD_SIZE(WORD_SIZE), .P(P)) u_half_x1 (
        .i_x      (x1_q),
        .i_bypass (~w_half_u),
        .o_y      (w_x1_half)
    );

    mod_half_p #(.WORD_SIZE(WORD_SIZE), .P(P)) u_half_x2 (
        .i_x      (x2_q),
        .i_bypass (~w_half_v),
        .o_y      (w_x2_half)
    );

    mod_sub_p #(.WORD_SIZE(WORD_SIZE), .P(P)) u_sub_x1 (
        .i_x (x1_q),
        .i_y (x2_q),
        .o_d (w_x1_sub)
    );

    mod_sub_p #(.WORD_SIZE(WORD_SIZE), .P(P)) u_sub_x2 (
        .i_x (x2_q),
        .i_y (x1_q),
        .o_d (w_x2_sub)
    );

    // One algorithm step (halve u, halve v, or subtract), applied in RUN
    // only when neither u nor v is already 1.
    always_comb begin
        w_u_nxt  = u_q;
        w_v_nxt  = v_q;
        w_x1_nxt = x1_q;
        w_x2_nxt = x2_q;
        if (w_u_even) begin
            w_u_nxt  = u_q >> 1;
            w_x1_nxt = w_x1_half;
        end else if (w_v_even) begin
            w_v_nxt  = v_q >> 1;
            w_x2_nxt = w_x2_half;
        end else if (w_u_ge_v) begin
            w_u_nxt  = u_q - v_q;
            w_x1_nxt = w_x1_sub;
        end else begin
            w_v_nxt  = v_q - u_q;
            w_x2_nxt = w_x2_sub;
        end
    end

    always_comb begin
        state_d    = state_q;
        u_d        = u_q;
        v_d        = v_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
`ifdef INV_TIMEOUT_EN
        step_d     = step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    out_data_d = '0;
                    out_err_d  = 1'b0;
                    if (bus.in_a == '0) begin
                        state_d   = ST_DONE;
                        out_err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        u_d     = bus.in_a;
                        v_d     = c_p;
                        x1_d    = c_one;
                        x2_d    = '0;
`ifdef INV_TIMEOUT_EN
                        step_d  = '0;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (u_q == c_one) begin
                    // Reached only for a == 1; other operands terminate
                    // inside the step that produces the unit.
                    state_d    = ST_DONE;
                    out_data_d = x1_q;
                end else if (v_q == c_one) begin
                    state_d    = ST_DONE;
                    out_data_d = x2_q;
                end else if (w_timeout) begin
                    state_d    = ST_DONE;
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                end else begin
                    u_d  = w_u_nxt;
                    v_d  = w_v_nxt;
                    x1_d = w_x1_nxt;
                    x2_d = w_x2_nxt;
`ifdef INV_TIMEOUT_EN
                    step_d = step_q + c_step_w'(1);
`endif
                    // Terminal test folded into the step that produces it,
                    // so an N-step inversion reports N+1 cycles after accept.
                    if (w_u_nxt == c_one) begin
                        state_d    = ST_DONE;
                        out_data_d = w_x1_nxt;
                    end else if (w_v_nxt == c_one) begin
                        state_d    = ST_DONE;
                        out_data_d = w_x2_nxt;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d    = ST_IDLE;
                    out_data_d = '0;
                    out_err_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
        // Working registers are don't-care until loaded on accept.
        u_q  <= u_d;
        v_q  <= v_d;
        x1_q <= x1_d;
        x2_q <= x2_d;
`ifdef INV_TIMEOUT_EN
        step_q <= step_d;
`endif
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
endmodule

`default_nettype wire

// File: tb/tb_binary_inv_ctrl.sv
// ============================================================================
// Module      : tb_binary_inv_ctrl
// Description : Self-checking bench for binary_inv_ctrl, WORD_SIZE=8, P=13.
//               A cycle-level reference (inverse by exhaustive search, step
//               count by integer EEA) predicts handshake timing and results.
//               With INV_TIMEOUT_EN defined, MAX_ITER=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_inv_ctrl;
    localparam int W  = 8;
    localparam int PR = 13;
`ifdef INV_TIMEOUT_EN
    localparam int MI = 3;
`else
    localparam int MI = 4 * W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    binary_inv_ctrl_if #(.WORD_SIZE(W)) bus ();

    binary_inv_ctrl #(.WORD_SIZE(W), .P(PR), .MAX_ITER(MI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: result from field arithmetic, latency from the step count.
    function automatic void ref_outcome(input int a, output int data, output int err, output int lat);
        int u, v, n;
        if (a == 0) begin
            data = 0; err = 1; lat = 1;
            return;
        end
        data = 0;
        for (int x = 1; x < PR; x++) if ((a * x) % PR == 1) data = x;
        u = a; v = PR; n = 0;
        while (u != 1 && v != 1 && n < 1000) begin
            if (u % 2 == 0)      u = u / 2;
            else if (v % 2 == 0) v = v / 2;
            else if (u >= v)     u = u - v;
            else                 v = v - u;
            n++;
        end
        err = 0;
        lat = (n == 0) ? 2 : n + 1;
`ifdef INV_TIMEOUT_EN
        if (n > MI) begin
            data = 0; err = 1; lat = MI + 2;
        end
`endif
    endfunction

    // Model state: 0 idle, 1 running, 2 result pending.
    int ph = 0;
    int rem = 0;
    int e_data = 0;
    int e_err = 0;
    bit fresh = 1'b1;
    bit started = 1'b0;
    bit acc_flag = 1'b0;

    always @(posedge clk) begin
        int lat;
        acc_flag = 1'b0;
        if (rst) begin
            ph = 0; fresh = 1'b1; started = 1'b1;
        end else begin
            case (ph)
                0: if (bus.in_valid === 1'b1) begin
                    acc_flag = 1'b1;
                    fresh = 1'b0;
                    ref_outcome(int'(bus.in_a), e_data, e_err, lat);
                    if (lat == 1) ph = 2;
                    else begin rem = lat - 1; ph = 1; end
                end
                1: begin
                    rem--;
                    if (rem == 0) ph = 2;
                end
                default: if (bus.out_ready === 1'b1) ph = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("in_ready", {31'b0, bus.in_ready}, {31'b0, ph == 0});
            check("out_valid", {31'b0, bus.out_valid}, {31'b0, ph == 2});
            if (ph == 2) begin
                check("out_data", {24'b0, bus.out_data}, e_data);
                check("out_err", {31'b0, bus.out_err}, e_err);
            end else if (ph == 0 && fresh) begin
                check("reset_out_data", {24'b0, bus.out_data}, 0);
                check("reset_out_err", {31'b0, bus.out_err}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int a, output bit ok);
        bus.in_valid = 1'b1;
        bus.in_a     = W'(a);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            #1 ok = acc_flag;
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom_range(0, PR - 1));
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic recv(input int hold, input bit chain, input int next_a,
                        output int data, output int err, output int lat);
        bus.out_ready = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (bus.out_valid !== 1'b1) check("result_timeout", 0, 1);
        data = int'(bus.out_data);
        err  = int'(bus.out_err);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_data", {24'b0, bus.out_data}, data);
            check("hold_err", {31'b0, bus.out_err}, err);
            check("hold_in_ready", {31'b0, bus.in_ready}, 0);
        end
        bus.out_ready = 1'b1;
        if (chain) begin
            bus.in_valid = 1'b1;
            bus.in_a     = W'(next_a);
        end
        tick();
        bus.out_ready = 1'($urandom_range(0, 1));
        check("in_ready_after_release", {31'b0, bus.in_ready}, 1);
    endtask

    task automatic run_one(input int a, input int hold, output int d, output int e, output int l);
        bit ok;
        int ed, ee, el;
        send(a, ok);
        recv(hold, 1'b0, 0, d, e, l);
        ref_outcome(a, ed, ee, el);
        check($sformatf("lat_a%0d", a), l, el);
        check($sformatf("data_a%0d", a), d, ed);
        check($sformatf("err_a%0d", a), e, ee);
    endtask

    initial begin
        int d, e, l;
        bit ok;
        int sweep_err [13];

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        rst = 1'b0;
        tick();

        // Pin the model with hand-derived values.
        ref_outcome(0, d, e, l);
        check("pin0_err", e, 1); check("pin0_lat", l, 1);
        ref_outcome(1, d, e, l);
        check("pin1_data", d, 1); check("pin1_lat", l, 2);
        ref_outcome(2, d, e, l);
        check("pin2_data", d, 7); check("pin2_lat", l, 2);
`ifndef INV_TIMEOUT_EN
        ref_outcome(12, d, e, l);
        check("pin12_data", d, 12); check("pin12_lat", l, 7);
`endif

        // Directed cases.
        run_one(1, 0, d, e, l);
        check("t1_data", d, 1); check("t1_err", e, 0); check("t1_lat", l, 2);
        run_one(2, 1, d, e, l);
        check("t2_data", d, 7); check("t2_lat", l, 2);
        run_one(12, 0, d, e, l);
`ifdef INV_TIMEOUT_EN
        check("t3_timeout_err", e, 1); check("t3_timeout_data", d, 0);
`else
        check("t3_data", d, 12); check("t3_lat", l, 7);
`endif
        run_one(0, 2, d, e, l);
        check("t4_err", e, 1); check("t4_data", d, 0); check("t4_lat", l, 1);

        // Result held under back-pressure, then an operand offered during
        // the release edge (must wait one cycle).
        send(3, ok);
        recv(5, 1'b1, 5, d, e, l);
`ifdef INV_TIMEOUT_EN
        check("t5_a3_err", e, 1);
`else
        check("t5_a3_data", d, 9);
`endif
        send(5, ok);
        recv(0, 1'b0, 0, d, e, l);
`ifdef INV_TIMEOUT_EN
        check("t5_a5_err", e, 1);
`else
        check("t5_a5_data", d, 8);
`endif

        // Reset while running.
        send(7, ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 1);
        tick();

        // Sweep every nonzero residue.
        for (int a = 1; a < PR; a++) begin
            run_one(a, 0, d, e, l);
            sweep_err[a] = e;
            if (e == 0) check($sformatf("sweep_prod_a%0d", a), (a * d) % PR, 1);
        end
`ifdef INV_TIMEOUT_EN
        check("sweep_timeout_a12", sweep_err[12], 1);
`endif

        // Randomized operands, back-pressure and idle gaps.
        repeat (40) begin
            int a, gap;
            a   = int'($urandom_range(0, PR - 1));
            gap = int'($urandom_range(0, 3));
            for (int i = 0; i < gap; i++) begin
                bus.in_a = W'($urandom_range(0, PR - 1));
                tick();
            end
            run_one(a, int'($urandom_range(0, 3)), d, e, l);
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire

// File: doc/binary_inv_ctrl.md
# binary_inv_ctrl

Sequential modular inverter: computes a⁻¹ mod p by the binary extended Euclidean algorithm, one algorithm step per clock. Sits in the inversion path of the pairing datapath, between the Fp operand scheduler and consumers of inverted values. It sequences the halving-mod-p and subtract-mod-p datapath, and owns the valid/ready handshake on both sides.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE ``: operand width in bits.
- `P`, default `` `CHAR ``: odd field characteristic; p < 2^WORD_SIZE.
- `MAX_ITER`, default 4*WORD_SIZE: step limit. Used only when timeout is compiled in.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand `in_a` is valid.
- `in_ready` out 1: block is able to accept an operand.
- `in_a` in WORD_SIZE: operand a; must satisfy 0 ≤ a < p.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out WORD_SIZE: a⁻¹ mod p, or 0 on error.
- `out_err` out 1: a == 0, or timeout.

## Operation
- **States:**
  - IDLE: `in_ready`=1.
  - RUN: iterating.
  - DONE: `out_valid`=1.
- **IDLE → RUN** on `in_valid & in_ready`. Load u=a, v=p, x1=1, x2=0, step=0.
- **IDLE → DONE** if a==0 on accept. Set `out_err`=1 and `out_data`=0.
- **RUN, each cycle, first matching rule in this order:**
  1. u==1 → DONE, `out_data`=x1.
  2. v==1 → DONE, `out_data`=x2.
  3. u even → u=u>>1, x1=half(x1).
  4. v even → v=v>>1, x2=half(x2).
  5. u ≥ v → u=u−v, x1=sub(x1,x2).
  6. Otherwise → v=v−u, x2=sub(x2,x1).
- **half(x):** x even → x>>1. x odd → (x+p)>>1, computed as a WORD_SIZE+1-bit sum with the carry forming the MSB. The result is always < p.
- **sub(x,y):** x≥y → x−y, else x−y+p. Operands are < p, so the result is < p.
- u and v fit in WORD_SIZE bits and are never incremented.
- **DONE → IDLE** on `out_ready`. `out_valid`, `out_data` and `out_err` hold stable until then.
- A new operand is not accepted in the same cycle as the DONE → IDLE transition; `in_ready` rises the following cycle.
- `in_a` must be reduced below p; behaviour for a ≥ p is undefined, and the bench must not drive it.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_err`=0. u, v, x1, x2 and step are don't-care.
- **Latency:** N+1 cycles from the accepting edge to `out_valid` high, where N is the number of halve/subtract steps. Worst case N < 4*WORD_SIZE.
- **a==0:** `out_valid` is high 1 cycle after accept.
- **Throughput:** one inversion in flight. `in_ready`=0 in RUN and DONE.
- **Mid-operation reset:** `rst` in RUN or DONE returns to IDLE on that edge. A pending result is dropped, and `out_valid` is 0 the next cycle.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.

## Configuration
- **`INV_TIMEOUT_EN` defined:**
  - Step counter of width $clog2(MAX_ITER+1).
  - If step reaches MAX_ITER in RUN without terminating → DONE with `out_err`=1, `out_data`=0.
  - Guards against an illegal p or a corrupted operand.
- **`INV_TIMEOUT_EN` undefined:**
  - No counter.
  - `out_err` is driven only by a==0.

## Structure
- **Shared package `inv_pkg`:**
  - State enum (IDLE/RUN/DONE).
  - Default MAX_ITER expression.
  - Helper width constant WORD_SIZE+1 for half-sums.
- **One sub-module, `mod_sub_p`:**
  - Combinational x−y mod p (borrow-select between x−y and x−y+p).
  - Instantiated twice, for x1−x2 and x2−x1.
- Halving lanes reuse the codebase's existing mod-p halving unit, with its bypass held high when the lane is idle.
- u/v compare and subtract stay inline in the controller.

## Test plan
Bench runs with WORD_SIZE=8, P=13.

1. **a=1:** `out_valid` 2 cycles after accept, `out_data`=1, `out_err`=0.
2. **a=2:** one halving step, then `out_data`=7; `out_valid` 2 cycles after accept.
3. **a=12:** 6 steps (x2 path), then `out_data`=12; `out_valid` 7 cycles after accept.
4. **a=0:** `out_valid` 1 cycle after accept, `out_err`=1, `out_data`=0.
5. **a=3 with `out_ready` held low for 5 cycles:**
   - `out_data`=9 stable throughout, `in_ready`=0.
   - After `out_ready` is asserted: `in_ready`=1 the next cycle.
   - Then a=5 back-to-back → 8.
6. **Reset mid-run, then sweep:**
   - Assert `rst` during RUN of a=7: next cycle IDLE, `out_valid`=0.
   - Then sweep a=1..12: every (a·out) mod 13 = 1.
   - With `INV_TIMEOUT_EN` defined and MAX_ITER=3: a=12 gives `out_err`=1.
